// File: rtl/fifo_sipo.sv
// Serial-in, parallel-out receive buffer: assembles LSB-first serial bits into
// WIDTH-bit words and queues them in a DEPTH-entry synchronous FIFO.
module fifo_sipo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sdata_i,
  input  logic                 svalid_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               wr_err_q, wr_err_d;
  logic               rd_err_q, rd_err_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             push;
  logic             pop;

  assign word      = {sdata_i, shift_q[WIDTH-1:1]};
  assign word_done = svalid_i && (bit_cnt_q == CntW'(WIDTH - 1));

  // Flags derive from the registered pointers only, so push/pop see pre-edge state.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                   (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign push = word_done && !full_o;
  assign pop  = rd_en_i && !empty_o;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rdata_d   = rdata_q;
    wr_err_d  = word_done && full_o;
    rd_err_d  = rd_en_i && empty_o;
    if (svalid_i) begin
      shift_d   = word;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CntW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rdata_q   <= '0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rdata_q   <= rdata_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= word;
    end
  end

  assign rdata_o    = rdata_q;
  assign wr_error_o = wr_err_q;
  assign rd_error_o = rd_err_q;

endmodule

// File: tb/tb_fifo_sipo.sv
// Testbench for fifo_sipo: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the receive buffer.
module tb_fifo_sipo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sdata = 1'b0;
  logic       svalid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       full, empty, wr_error, rd_error;
  logic [4:0] count;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model
  logic [7:0] mdl_q[$];
  logic [7:0] mdl_acc = 8'h00;
  int         mdl_nbits = 0;
  logic [7:0] mdl_rdata = 8'h00;
  logic       mdl_wr_err = 1'b0;
  logic       mdl_rd_err = 1'b0;
  logic [7:0] popped[$];

  fifo_sipo #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sdata_i    (sdata),
    .svalid_i   (svalid),
    .rd_en_i    (rd_en),
    .rdata_o    (rdata),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .wr_error_o (wr_error),
    .rd_error_o (rd_error)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle and advance the model; outputs settle by return.
  task automatic cycle(input logic sd, input logic sv, input logic rd, input logic rs);
    bit pre_full, pre_empty;
    sdata  = sd;
    svalid = sv;
    rd_en  = rd;
    rst    = rs;
    @(posedge clk);
    if (rs) begin
      mdl_q.delete();
      mdl_acc    = 8'h00;
      mdl_nbits  = 0;
      mdl_rdata  = 8'h00;
      mdl_wr_err = 1'b0;
      mdl_rd_err = 1'b0;
    end else begin
      pre_full   = (mdl_q.size() == 16);
      pre_empty  = (mdl_q.size() == 0);
      mdl_wr_err = 1'b0;
      mdl_rd_err = rd && pre_empty;
      if (rd && !pre_empty) begin
        mdl_rdata = mdl_q.pop_front();
        popped.push_back(mdl_rdata);
      end
      if (sv) begin
        mdl_acc[mdl_nbits] = sd;
        mdl_nbits++;
        if (mdl_nbits == 8) begin
          if (pre_full) mdl_wr_err = 1'b1;
          else mdl_q.push_back(mdl_acc);
          mdl_nbits = 0;
          mdl_acc   = 8'h00;
        end
      end
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps, input bit rd_when_avail);
    for (int i = 0; i < 8; i++) begin
      if (gaps) cycle(1'($urandom), 1'b0, 1'b0, 1'b0);
      cycle(w[i], 1'b1, rd_when_avail && (mdl_q.size() != 0), 1'b0);
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++;
    if (wr_error !== 1'b0 || rd_error !== 1'b0) begin
      n_bad++; $display("FAIL reset_errors: got wr=%b rd=%b want 0 0", wr_error, rd_error);
    end
  endtask

  task automatic test_basic(input bit gaps);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, gaps, 1'b0);
    n_vec++; if (empty !== 1'b0) begin n_bad++; $display("FAIL a5_empty(gaps=%0d): got %b want 0", gaps, empty); end
    n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL a5_count(gaps=%0d): got %0d want 1", gaps, count); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL a5_rdata(gaps=%0d): got %h want a5", gaps, rdata); end
    n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL a5_drained(gaps=%0d): got %b want 1", gaps, empty); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 16; w++) send_word(8'(w), 1'b0, 1'b0);
    n_vec++; if (full !== 1'b1) begin n_bad++; $display("FAIL ovf_full: got %b want 1", full); end
    n_vec++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", count); end
    send_word(8'hFF, 1'b0, 1'b0);
    n_vec++; if (wr_error !== 1'b1) begin n_bad++; $display("FAIL ovf_wr_error: got %b want 1", wr_error); end
    n_vec++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count_hold: got %0d want 16", count); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_error !== 1'b0) begin n_bad++; $display("FAIL ovf_wr_error_pulse: got %b want 0", wr_error); end
    for (int w = 0; w < 16; w++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (rdata !== 8'(w)) begin n_bad++; $display("FAIL ovf_read%0d: got %h want %h", w, rdata, 8'(w)); end
    end
    n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got %b want 1", empty); end
  endtask

  task automatic test_empty_read();
    logic [7:0] prev;
    prev = mdl_rdata;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (rd_error !== 1'b1) begin n_bad++; $display("FAIL er_rd_error%0d: got %b want 1", i, rd_error); end
      n_vec++; if (rdata !== prev) begin n_bad++; $display("FAIL er_rdata%0d: got %h want %h", i, rdata, prev); end
      n_vec++; if (count !== 5'd0) begin n_bad++; $display("FAIL er_count%0d: got %0d want 0", i, count); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (rd_error !== 1'b0) begin n_bad++; $display("FAIL er_rd_error_clear: got %b want 0", rd_error); end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0);
    n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL mid_count: got %0d want 1", count); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL mid_rdata: got %h want 3c", rdata); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 16; w++) send_word(8'($urandom), 1'b0, 1'b0);
    for (int w = 0; w < 16; w++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (popped.size() != 4) begin
      n_bad++; $display("FAIL wrap_pops: got %0d pops want 4", popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (popped[i] !== 8'(i + 1)) begin
          n_bad++; $display("FAIL wrap_order%0d: got %h want %h", i, popped[i], 8'(i + 1));
        end
      end
    end
    n_vec++; if (rdata !== 8'h04) begin n_bad++; $display("FAIL wrap_rdata: got %h want 04", rdata); end
    n_vec++; if (empty !== 1'b1 || count !== 5'd0) begin
      n_bad++; $display("FAIL wrap_empty: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_random();
    bit rd;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      // Vary read pressure so the FIFO sweeps between empty and full.
      rd = ((i / 400) % 2 == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 999) == 0));
      n_vec++;
      if (count !== 5'(mdl_q.size()) || empty !== (mdl_q.size() == 0) ||
          full !== (mdl_q.size() == 16) || rdata !== mdl_rdata ||
          wr_error !== mdl_wr_err || rd_error !== mdl_rd_err) begin
        n_bad++;
        $display("FAIL random%0d: got cnt=%0d e=%b f=%b rd=%h we=%b re=%b want cnt=%0d rd=%h we=%b re=%b",
                 i, count, empty, full, rdata, wr_error, rd_error, mdl_q.size(), mdl_rdata,
                 mdl_wr_err, mdl_rd_err);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_overflow();
    test_empty_read();
    test_reset_midword();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sipo.md
# fifo_sipo

Serial-in, parallel-out receive buffer. It is the receiving end of the team's parallel-in/serial-out FIFO path. It samples a qualified serial bit stream LSB first and assembles WIDTH-bit words. Each completed word goes into a DEPTH-entry synchronous FIFO, which a downstream reader drains with a read-enable handshake and full/empty/error flags.

## Interface
- WIDTH, 8, bits per assembled word
- DEPTH, 16, FIFO entries (power of two, equal to 2**PTR_WIDTH)
- PTR_WIDTH, 4, FIFO address width
- clk_i  input  1  single clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- sdata_i  input  1  serial data bit
- svalid_i  input  1  sdata_i is sampled on this edge when high
- rd_en_i  input  1  pop request from downstream
- rdata_o  output  WIDTH  popped word, registered
- full_o  output  1  FIFO holds DEPTH words
- empty_o  output  1  FIFO holds 0 words
- count_o  output  PTR_WIDTH+1  words currently stored (0..DEPTH)
- wr_error_o  output  1  one-cycle pulse: completed word dropped because FIFO full
- rd_error_o  output  1  one-cycle pulse: rd_en_i while FIFO empty

## Operation
- Reset is synchronous: clk_i edge with rst_i=1. After reset:
  - shift register = 0, bit counter = 0
  - write and read pointers = 0
  - rdata_o = 0, empty_o = 1, full_o = 0, count_o = 0
  - wr_error_o = 0, rd_error_o = 0
  - rst_i overrides all other inputs on that edge.
- Deserializer:
  - svalid_i=1: shift_q <= {sdata_i, shift_q[WIDTH-1:1]} (first bit lands in bit 0 of the final word); bit counter increments.
  - svalid_i=0: shift register and counter hold. Gaps between bits are legal.
  - When svalid_i=1 and counter = WIDTH-1, the word is complete: word = {sdata_i, shift_q[WIDTH-1:1]}. The counter returns to 0 on the same edge.
- Push: on a completing edge, if full_o=0, write word to mem[wr_ptr[PTR_WIDTH-1:0]] and increment wr_ptr.
- Dropped word: on a completing edge, if full_o=1, discard the word, pulse wr_error_o for one cycle, and still restart the counter.
- Pop: rd_en_i=1 and empty_o=0 loads rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]] and increments rd_ptr.
- Empty read: rd_en_i=1 and empty_o=1 pulses rd_error_o for one cycle; rdata_o holds.
- rdata_o holds its last value whenever no pop occurs.
- Pointers are PTR_WIDTH+1 bits and wrap naturally modulo 2**(PTR_WIDTH+1).
  - empty_o: wr_ptr == rd_ptr.
  - full_o: MSBs differ and lower PTR_WIDTH bits are equal.
  - count_o = wr_ptr - rd_ptr, modulo 2**(PTR_WIDTH+1).
  - All three are combinational from the registered pointers.
- Simultaneous push and pop are both evaluated against the pre-edge flags:
  - Neither full nor empty: both occur; count_o unchanged.
  - Full with pop: pop occurs, push is dropped, wr_error_o pulses. No pass-through.
  - Empty with completed word: push occurs, rd_error_o pulses. No bypass.
- Reset mid-word: partial bits are discarded; the next WIDTH valid bits form a fresh word.

## Timing
- Push latency: the word is visible (empty_o=0, count_o incremented) on the edge that samples its WIDTH-th valid bit.
- Pop latency: rdata_o is valid in the cycle after the edge where rd_en_i=1 was sampled.
- rd_en_i may be held high for back-to-back pops, one word per cycle.
- Error pulses are registered: high for exactly the one cycle after the offending edge.
- Sustained rate: one word per WIDTH valid bit cycles in, one word per cycle out.

## Test plan
- Reset, then shift 1,0,1,0,0,1,0,1 with svalid_i=1 -> after the 8th edge, empty_o=0 and count_o=1. Pulse rd_en_i -> rdata_o=8'hA5 next cycle, empty_o=1.
- Same 0xA5 stream with svalid_i=0 inserted between every bit -> identical result. Bits presented with svalid_i=0 are ignored.
- Push 16 words 8'h00..8'h0F -> full_o=1, count_o=16. Shift a 17th word 8'hFF -> wr_error_o pulses once, count_o stays 16. Reading 16 returns 8'h00..8'h0F in order.
- From empty, rd_en_i=1 for 2 cycles -> rd_error_o high for 2 cycles, rdata_o unchanged, count_o=0.
- Shift 5 bits, assert rst_i for one edge, then shift 8'h3C -> count_o=1 and the read returns 8'h3C.
- Wrap: write 16, read 16, write 8'h01..8'h04 while reading concurrently once non-empty -> reads return 8'h01..8'h04 in order, ending with empty_o=1 and pointers past wrap.
